// File: rtl/sfm_pkg.sv
// Shared definitions for the DMB serial-flash (SFM) bus: opcodes, FSM states,
// status bit positions and the status-byte helper.
package sfm_pkg;

    localparam logic [7:0] SFM_OP_READ = 8'h03;
    localparam logic [7:0] SFM_OP_PROG = 8'h02;
    localparam logic [7:0] SFM_OP_WREN = 8'h06;
    localparam logic [7:0] SFM_OP_RDSR = 8'h05;

    localparam int SFM_ST_WIP = 0;
    localparam int SFM_ST_WEL = 1;
    localparam int SFM_ST_WPN = 7;

    localparam int SFM_PAGE_BYTES = 8;
    localparam int SFM_PAGE_IDX_W = $clog2(SFM_PAGE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_RDATA,
        ST_WDATA,
        ST_STAT,
        ST_WAITCS
    } sfm_state_e;

    function automatic logic [7:0] sfm_status(input logic wp_b, input logic wel, input logic wip);
        logic [7:0] s;
        s             = '0;
        s[SFM_ST_WPN] = ~wp_b;
        s[SFM_ST_WEL] = wel;
        s[SFM_ST_WIP] = wip;
        return s;
    endfunction

endpackage

// File: rtl/sfm_responder_if.sv
// SFM serial bus between the serfmem master and a flash (or this responder).
interface sfm_responder_if;

    logic SFMSCK;
    logic SFMCS_B;
    logic SFMSI;
    logic SFMWP_B;
    logic SFMRST_B;
    logic SFMSO;

    modport master (
        output SFMSCK, SFMCS_B, SFMSI, SFMWP_B, SFMRST_B,
        input  SFMSO
    );

    modport slave (
        input  SFMSCK, SFMCS_B, SFMSI, SFMWP_B, SFMRST_B,
        output SFMSO
    );

endinterface

// File: rtl/sfm_in_sync.sv
// Registers SFMSCK and SFMCS_B and turns them into single-cycle edge strobes;
// strobes combine the live input with its registered copy, so they need no extra latency.
module sfm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs_b,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic sck_q, sck_d;
    logic cs_b_q, cs_b_d;

    always_comb begin
        sck_d  = sck;
        cs_b_d = cs_b;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values; always_comb uses = .
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= 1'b0;
            cs_b_q <= 1'b1;
        end else begin
            sck_q  <= sck_d;
            cs_b_q <= cs_b_d;
        end
    end

    assign sck_rise = sck & ~sck_q;
    assign sck_fall = ~sck & sck_q;
    assign cs_fall  = ~cs_b & cs_b_q;
    assign cs_rise  = cs_b & ~cs_b_q;

endmodule

// File: rtl/sfm_responder.sv
// SFM flash responder: decodes READ/PROG/WREN/RDSR from the serial bus, answers on SO,
// holds a small register-based storage array and emulates program busy time.
module sfm_responder
    import sfm_pkg::*;
#(
    parameter int                     MEM_BYTES = 8,
    parameter int                     PROG_CYC  = 64,
    parameter logic [8*MEM_BYTES-1:0] INIT      = '0
) (
    input  logic                     CLKCMS,
    input  logic                     RST_B,
    sfm_responder_if.slave           sfm,
    output logic                     BUSY,
    output logic [8*MEM_BYTES-1:0]   MEMDOUT,
    output logic [7:0]               CMDCNT
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int WW = $clog2(PROG_CYC + 1);

    logic sck_rise, sck_fall, cs_fall, cs_rise;

    sfm_in_sync u_sync (
        .clk      (CLKCMS),
        .rst_n    (RST_B),
        .sck      (sfm.SFMSCK),
        .cs_b     (sfm.SFMCS_B),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    sfm_state_e                           state_q, state_d;
    logic [4:0]                           bit_cnt_q, bit_cnt_d;
    logic [23:0]                          shreg_q, shreg_d;
    logic [AW-1:0]                        addr_q, addr_d;
    logic                                 so_q, so_d;
    logic                                 wel_q, wel_d;
    logic                                 done_q, done_d;
    logic                                 is_prog_q, is_prog_d;
    logic [7:0]                           cmd_cnt_q, cmd_cnt_d;
    logic [WW-1:0]                        wip_cnt_q, wip_cnt_d;
    logic [MEM_BYTES-1:0][7:0]            mem_q, mem_d;
    logic [SFM_PAGE_BYTES-1:0][7:0]       page_data_q, page_data_d;
    logic [SFM_PAGE_BYTES-1:0][AW-1:0]    page_addr_q, page_addr_d;
    logic [SFM_PAGE_BYTES-1:0]            page_vld_q, page_vld_d;

    logic                                 wip;
    logic [23:0]                          rx_bits;
    logic [7:0]                           rx_byte;
    logic [7:0]                           status;
    logic                                 commit;

    assign wip     = (wip_cnt_q != '0);
    assign rx_bits = {shreg_q[22:0], sfm.SFMSI};
    assign rx_byte = rx_bits[7:0];
    assign status  = sfm_status(sfm.SFMWP_B, wel_q, wip);

    // The MSB of the address shifter falls off the end; only the low AW bits address storage.
    logic unused_shreg_msb;
    assign unused_shreg_msb = shreg_q[23];

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        so_d        = so_q;
        wel_d       = wel_q;
        done_d      = done_q;
        is_prog_d   = is_prog_q;
        cmd_cnt_d   = cmd_cnt_q;
        mem_d       = mem_q;
        page_data_d = page_data_q;
        page_addr_d = page_addr_q;
        page_vld_d  = page_vld_q;
        commit      = 1'b0;
        wip_cnt_d   = wip ? wip_cnt_q - WW'(1) : '0;

        if (!sfm.SFMRST_B) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            so_d      = 1'b0;
            done_d    = 1'b0;
            wel_d     = 1'b0;
            wip_cnt_d = '0;
        end else if (sfm.SFMCS_B) begin
            // CS_B high dominates any SCK edge seen in the same cycle.
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            so_d      = 1'b0;
            done_d    = 1'b0;
            if (cs_rise) begin
                commit = (state_q == ST_WDATA) && wel_q && sfm.SFMWP_B && (page_vld_q != '0);
                if (commit) begin
                    for (int i = 0; i < SFM_PAGE_BYTES; i++) begin
                        if (page_vld_q[i]) mem_d[page_addr_q[i]] = page_data_q[i];
                    end
                    wel_d     = 1'b0;
                    wip_cnt_d = WW'(PROG_CYC);
                end
                if (commit || done_q) cmd_cnt_d = cmd_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_OPCODE;
                        bit_cnt_d = '0;
                    end
                end
                ST_OPCODE: begin
                    if (sck_rise) begin
                        shreg_d   = rx_bits;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            is_prog_d = (rx_byte == SFM_OP_PROG);
                            case (rx_byte)
                                SFM_OP_READ, SFM_OP_PROG: begin
                                    if (wip) begin
                                        state_d = ST_WAITCS;
                                    end else begin
                                        state_d    = ST_ADDR;
                                        page_vld_d = '0;
                                    end
                                end
                                SFM_OP_WREN: begin
                                    state_d = ST_WAITCS;
                                    wel_d   = 1'b1;
                                    done_d  = 1'b1;
                                end
                                SFM_OP_RDSR: begin
                                    state_d = ST_STAT;
                                    done_d  = 1'b1;
                                end
                                default: state_d = ST_WAITCS;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        shreg_d   = rx_bits;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            addr_d    = rx_bits[AW-1:0];
                            state_d   = is_prog_q ? ST_WDATA : ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        so_d      = mem_q[addr_q][3'd7 - bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + AW'(1);
                            done_d    = 1'b1;
                        end
                    end
                end
                ST_STAT: begin
                    if (sck_fall) begin
                        so_d      = status[3'd7 - bit_cnt_q[2:0]];
                        bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        shreg_d   = rx_bits;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            page_data_d[addr_q[SFM_PAGE_IDX_W-1:0]] = rx_byte;
                            page_addr_d[addr_q[SFM_PAGE_IDX_W-1:0]] = addr_q;
                            page_vld_d[addr_q[SFM_PAGE_IDX_W-1:0]]  = 1'b1;
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                ST_WAITCS: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: storage is reset because the part must power up holding INIT; the page buffer is
    // reset too so a refused or aborted program can never leak stale bytes.
    always_ff @(posedge CLKCMS or negedge RST_B) begin
        if (!RST_B) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            so_q        <= 1'b0;
            wel_q       <= 1'b0;
            done_q      <= 1'b0;
            is_prog_q   <= 1'b0;
            cmd_cnt_q   <= '0;
            wip_cnt_q   <= '0;
            mem_q       <= INIT;
            page_data_q <= '0;
            page_addr_q <= '0;
            page_vld_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            so_q        <= so_d;
            wel_q       <= wel_d;
            done_q      <= done_d;
            is_prog_q   <= is_prog_d;
            cmd_cnt_q   <= cmd_cnt_d;
            wip_cnt_q   <= wip_cnt_d;
            mem_q       <= mem_d;
            page_data_q <= page_data_d;
            page_addr_q <= page_addr_d;
            page_vld_q  <= page_vld_d;
        end
    end

    assign sfm.SFMSO = so_q;
    assign BUSY      = wip;
    assign MEMDOUT   = mem_q;
    assign CMDCNT    = cmd_cnt_q;

endmodule
